// File: rtl/maze_pkg.sv
// Shared direction/state encodings and default maze dimensions for the move controller.
package maze_pkg;
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    COOLDOWN = 2'd2,
    DONE     = 2'd3
  } ctrl_state_t;

  localparam int MAZE_SIZE_Y = 20;
  localparam int MAZE_SIZE_X = 40;
  localparam int X_W = $clog2(MAZE_SIZE_X);
  localparam int Y_W = $clog2(MAZE_SIZE_Y);
endpackage

// File: rtl/maze_constraint_lookup.sv
// Combinational blocked decision for a registered move target; no state, no backpressure.
// Arrays are flattened row-major: cell [y][x] lives at bit y*size_x + x.
module maze_constraint_lookup
  import maze_pkg::*;
#(
  parameter int size_y = MAZE_SIZE_Y,
  parameter int size_x = MAZE_SIZE_X
) (
  input  logic [size_y*size_x-1:0]  up_constraint,
  input  logic [size_y*size_x-1:0]  down_constraint,
  input  logic [size_y*size_x-1:0]  left_constraint,
  input  logic [size_y*size_x-1:0]  right_constraint,
  input  logic [$clog2(size_x)-1:0] tgt_x,
  input  logic [$clog2(size_y)-1:0] tgt_y,
  input  logic [1:0]                dir,
  input  logic                      off_grid,
  output logic                      blocked
);
  localparam int IW = $clog2(size_y*size_x);

  logic [IW-1:0] idx;

  // Off-grid targets are held at the current position upstream, so idx stays in range.
  assign idx = IW'(tgt_y) * IW'(size_x) + IW'(tgt_x);

  always_comb begin
    blocked = off_grid;
    if (!off_grid) begin
      case (dir)
        DIR_UP:    blocked = up_constraint[idx];
        DIR_DOWN:  blocked = down_constraint[idx];
        DIR_LEFT:  blocked = left_constraint[idx];
        default:   blocked = right_constraint[idx];
      endcase
    end
  end
endmodule

// File: rtl/maze_move_controller.sv
// One move at a time via valid/ready; move_done/move_blocked pulse 2 cycles after accept.
// Ready drops during CHECK, cooldown and goal (DONE); requests must be held until accepted.
module maze_move_controller
  import maze_pkg::*;
#(
  parameter int size_y      = MAZE_SIZE_Y,
  parameter int size_x      = MAZE_SIZE_X,
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int GOAL_X      = 39,
  parameter int GOAL_Y      = 19,
  parameter int HOLD_CYCLES = 4,
  parameter int STEP_W      = 16
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      restart,
  input  logic                      move_valid,
  input  logic [1:0]                move_dir,
  output logic                      move_ready,
  input  logic [size_y*size_x-1:0]  up_constraint,
  input  logic [size_y*size_x-1:0]  down_constraint,
  input  logic [size_y*size_x-1:0]  left_constraint,
  input  logic [size_y*size_x-1:0]  right_constraint,
  output logic [$clog2(size_x)-1:0] pos_x,
  output logic [$clog2(size_y)-1:0] pos_y,
  output logic                      move_done,
  output logic                      move_blocked,
  output logic                      goal_reached,
  output logic [STEP_W-1:0]         step_count
);
  localparam int XW = $clog2(size_x);
  localparam int YW = $clog2(size_y);
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int CNT_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_CHECK    = CHECK;
  localparam logic [1:0] S_COOLDOWN = COOLDOWN;
  localparam logic [1:0] S_DONE     = DONE;

  localparam logic [XW-1:0] SX   = XW'(START_X);
  localparam logic [YW-1:0] SY   = YW'(START_Y);
  localparam logic [XW-1:0] GX   = XW'(GOAL_X);
  localparam logic [YW-1:0] GY   = YW'(GOAL_Y);
  localparam logic [XW-1:0] XMAX = XW'(size_x - 1);
  localparam logic [YW-1:0] YMAX = YW'(size_y - 1);

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     pos_x_q, pos_x_d, tgt_x_q, tgt_x_d;
  logic [YW-1:0]     pos_y_q, pos_y_d, tgt_y_q, tgt_y_d;
  logic [1:0]        dir_q, dir_d;
  logic              off_q, off_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              goal_q, goal_d;
  logic              done_q, done_d, blk_q, blk_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              blocked;

  maze_constraint_lookup #(.size_y(size_y), .size_x(size_x)) u_lookup (
    .up_constraint   (up_constraint),
    .down_constraint (down_constraint),
    .left_constraint (left_constraint),
    .right_constraint(right_constraint),
    .tgt_x           (tgt_x_q),
    .tgt_y           (tgt_y_q),
    .dir             (dir_q),
    .off_grid        (off_q),
    .blocked         (blocked)
  );

  assign move_ready = (state_q == S_IDLE) && !restart;

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    dir_d   = dir_q;
    off_d   = off_q;
    steps_d = steps_q;
    goal_d  = goal_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    blk_d   = 1'b0;
    if (restart) begin
      state_d = S_IDLE;
      pos_x_d = SX;
      pos_y_d = SY;
      steps_d = '0;
      goal_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (move_valid) begin
          dir_d   = move_dir;
          tgt_x_d = pos_x_q;
          tgt_y_d = pos_y_q;
          off_d   = 1'b0;
          // Off-grid moves keep the target at pos so the lookup index is always legal.
          case (move_dir)
            DIR_UP:   if (pos_y_q == '0)  off_d = 1'b1; else tgt_y_d = pos_y_q - 1'b1;
            DIR_DOWN: if (pos_y_q == YMAX) off_d = 1'b1; else tgt_y_d = pos_y_q + 1'b1;
            DIR_LEFT: if (pos_x_q == '0)  off_d = 1'b1; else tgt_x_d = pos_x_q - 1'b1;
            default:  if (pos_x_q == XMAX) off_d = 1'b1; else tgt_x_d = pos_x_q + 1'b1;
          endcase
          state_d = S_CHECK;
        end
        S_CHECK: begin
          cnt_d   = CW'(CNT_LOAD);
          state_d = (HOLD_CYCLES > 0) ? S_COOLDOWN : S_IDLE;
          if (blocked) begin
            blk_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            pos_x_d = tgt_x_q;
            pos_y_d = tgt_y_q;
            if (steps_q != '1) steps_d = steps_q + 1'b1;
            if (tgt_x_q == GX && tgt_y_q == GY) begin
              goal_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_COOLDOWN: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d = cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pos_x_q <= SX;
      pos_y_q <= SY;
      tgt_x_q <= SX;
      tgt_y_q <= SY;
      dir_q   <= 2'd0;
      off_q   <= 1'b0;
      steps_q <= '0;
      goal_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      dir_q   <= dir_d;
      off_q   <= off_d;
      steps_q <= steps_d;
      goal_q  <= goal_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      blk_q   <= blk_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign step_count   = steps_q;
  assign goal_reached = goal_q;
  assign move_done    = done_q;
  assign move_blocked = blk_q;
endmodule
